// File: rtl/mips_cpu_monitor_pkg.sv
// Shared types and constants for the MIPS CPU run monitor.
package mips_cpu_monitor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_HALTED  = 3'd2,
    ST_TIMEOUT = 3'd3,
    ST_ERROR   = 3'd4
  } status_e;

  localparam logic [1:0] ERR_NONE        = 2'd0;
  localparam logic [1:0] ERR_FIRST_FETCH = 2'd1;
  localparam logic [1:0] ERR_RD_WR       = 2'd2;
  localparam logic [1:0] ERR_ACTIVE_DROP = 2'd3;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;

endpackage

// File: rtl/mips_cpu_sat_counter.sv
// Saturating up-counter with enable and async active-low clear.
module mips_cpu_sat_counter #(
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  output logic [CW-1:0] count_o
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != {CW{1'b1}})) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/mips_cpu_run_monitor.sv
// Run supervision for mips_cpu_harvard: halt detection, $v0 capture,
// cycle/access counting and timeout / protocol error flagging.
module mips_cpu_run_monitor
  import mips_cpu_monitor_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int          MAX_CYCLES   = 1000,
  parameter int          CW           = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_enable,
  input  logic          active,
  input  logic [31:0]   instr_address,
  input  logic [31:0]   register_v0,
  input  logic          data_read,
  input  logic          data_write,
  output logic [2:0]    status,
  output logic          done,
  output logic [31:0]   result_v0,
  output logic [CW-1:0] cycle_count,
  output logic [CW-1:0] rd_count,
  output logic [CW-1:0] wr_count,
  output logic [1:0]    err_code
);

  localparam logic [CW-1:0] LAST_CYCLE = CW'(MAX_CYCLES - 1);

  status_e     state_q, state_d;
  logic        first_fetch_q, first_fetch_d;
  logic [31:0] result_q, result_d;
  logic [1:0]  err_q, err_d;
  logic        run_en;

  assign run_en = clk_enable && (state_q == ST_RUN);

  always_comb begin
    state_d       = state_q;
    first_fetch_d = first_fetch_q;
    result_d      = result_q;
    err_d         = err_q;
    case (state_q)
      ST_IDLE: begin
        if (active) state_d = ST_RUN;
      end
      ST_RUN: begin
        first_fetch_d = 1'b0;
        // Errors outrank halt, and halt outranks timeout on the same edge.
        if (first_fetch_q && (instr_address != RESET_VECTOR)) begin
          state_d = ST_ERROR;
          err_d   = ERR_FIRST_FETCH;
        end else if (data_read && data_write) begin
          state_d = ST_ERROR;
          err_d   = ERR_RD_WR;
        end else if (!active && (instr_address == 32'd0)) begin
          state_d  = ST_HALTED;
          result_d = register_v0;
        end else if (!active) begin
          state_d = ST_ERROR;
          err_d   = ERR_ACTIVE_DROP;
        end else if (cycle_count == LAST_CYCLE) begin
          state_d = ST_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      first_fetch_q <= 1'b1;
      result_q      <= '0;
      err_q         <= ERR_NONE;
    end else if (clk_enable) begin
      state_q       <= state_d;
      first_fetch_q <= first_fetch_d;
      result_q      <= result_d;
      err_q         <= err_d;
    end
  end

  mips_cpu_sat_counter #(.CW(CW)) u_cycle_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .en_i    (run_en),
    .count_o (cycle_count)
  );

  mips_cpu_sat_counter #(.CW(CW)) u_rd_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .en_i    (run_en && data_read),
    .count_o (rd_count)
  );

  mips_cpu_sat_counter #(.CW(CW)) u_wr_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .en_i    (run_en && data_write),
    .count_o (wr_count)
  );

  assign status    = state_q;
  assign done      = (state_q == ST_HALTED) || (state_q == ST_TIMEOUT) || (state_q == ST_ERROR);
  assign result_v0 = result_q;
  assign err_code  = err_q;

endmodule

// File: tb/tb_mips_cpu_run_monitor.sv
// Directed bench for mips_cpu_run_monitor, built with MAX_CYCLES=8.
module tb_mips_cpu_run_monitor;

  localparam logic [31:0] RV = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_enable = 1'b1;
  logic        active = 1'b0;
  logic [31:0] instr_address = '0;
  logic [31:0] register_v0 = '0;
  logic        data_read = 1'b0;
  logic        data_write = 1'b0;
  logic [2:0]  status;
  logic        done;
  logic [31:0] result_v0;
  logic [31:0] cycle_count, rd_count, wr_count;
  logic [1:0]  err_code;

  int tests_run = 0;
  int tests_failed = 0;

  mips_cpu_run_monitor #(.RESET_VECTOR(RV), .MAX_CYCLES(8), .CW(32)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .active(active),
    .instr_address(instr_address), .register_v0(register_v0),
    .data_read(data_read), .data_write(data_write), .status(status),
    .done(done), .result_v0(result_v0), .cycle_count(cycle_count),
    .rd_count(rd_count), .wr_count(wr_count), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    clk_enable = 1'b1; active = 1'b0; instr_address = '0; register_v0 = '0;
    data_read = 1'b0; data_write = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic start_run();
    active = 1'b1; instr_address = RV;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (status !== 3'd0) begin tests_failed++; $display("FAIL reset.status got %0d exp 0", status); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset.done got %0b exp 0", done); end
    tests_run++; if (result_v0 !== 32'd0) begin tests_failed++; $display("FAIL reset.result got %0h exp 0", result_v0); end
    tests_run++; if ({cycle_count, rd_count, wr_count} !== 96'd0) begin tests_failed++; $display("FAIL reset.counters got %0d/%0d/%0d exp 0", cycle_count, rd_count, wr_count); end
    tests_run++; if (err_code !== 2'd0) begin tests_failed++; $display("FAIL reset.err got %0d exp 0", err_code); end
    for (int i = 0; i < 3; i++) step();
    tests_run++; if (status !== 3'd0) begin tests_failed++; $display("FAIL idle_hold.status got %0d exp 0", status); end
  endtask

  task automatic test_halt();
    do_reset();
    start_run();
    tests_run++; if (status !== 3'd1 || cycle_count !== 32'd0) begin tests_failed++; $display("FAIL halt.enter got st=%0d cyc=%0d exp st=1 cyc=0", status, cycle_count); end
    step();
    instr_address = RV + 32'd4; step();
    active = 1'b0; instr_address = '0; register_v0 = 32'd1; step();
    tests_run++; if (status !== 3'd2) begin tests_failed++; $display("FAIL halt.status got %0d exp 2", status); end
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL halt.done got %0b exp 1", done); end
    tests_run++; if (result_v0 !== 32'd1) begin tests_failed++; $display("FAIL halt.result got %0h exp 1", result_v0); end
    tests_run++; if (cycle_count !== 32'd3) begin tests_failed++; $display("FAIL halt.cycles got %0d exp 3", cycle_count); end
    active = 1'b1; register_v0 = 32'd5; data_read = 1'b1; step(); step();
    tests_run++; if (status !== 3'd2 || result_v0 !== 32'd1 || cycle_count !== 32'd3 || rd_count !== 32'd0) begin tests_failed++; $display("FAIL halt.sticky got st=%0d res=%0h cyc=%0d rd=%0d exp st=2 res=1 cyc=3 rd=0", status, result_v0, cycle_count, rd_count); end
  endtask

  task automatic test_bad_first_fetch();
    do_reset();
    start_run();
    instr_address = RV + 32'd4; step();
    tests_run++; if (status !== 3'd4 || err_code !== 2'd1) begin tests_failed++; $display("FAIL first_fetch got st=%0d err=%0d exp st=4 err=1", status, err_code); end
    tests_run++; if (cycle_count !== 32'd1) begin tests_failed++; $display("FAIL first_fetch.cycles got %0d exp 1", cycle_count); end
  endtask

  task automatic test_rd_wr();
    do_reset();
    start_run();
    data_read = 1'b1; step();
    step();
    data_read = 1'b0; data_write = 1'b1; step();
    tests_run++; if (status !== 3'd1) begin tests_failed++; $display("FAIL rdwr.mid_status got %0d exp 1", status); end
    data_read = 1'b1; step();
    tests_run++; if (status !== 3'd4 || err_code !== 2'd2) begin tests_failed++; $display("FAIL rdwr.err got st=%0d err=%0d exp st=4 err=2", status, err_code); end
    tests_run++; if (rd_count !== 32'd3 || wr_count !== 32'd2) begin tests_failed++; $display("FAIL rdwr.counts got rd=%0d wr=%0d exp rd=3 wr=2", rd_count, wr_count); end
    tests_run++; if (cycle_count !== 32'd4) begin tests_failed++; $display("FAIL rdwr.cycles got %0d exp 4", cycle_count); end
  endtask

  task automatic test_timeout();
    do_reset();
    start_run();
    for (int i = 0; i < 7; i++) step();
    tests_run++; if (status !== 3'd1 || cycle_count !== 32'd7) begin tests_failed++; $display("FAIL timeout.pre got st=%0d cyc=%0d exp st=1 cyc=7", status, cycle_count); end
    step();
    tests_run++; if (status !== 3'd3 || done !== 1'b1) begin tests_failed++; $display("FAIL timeout.status got st=%0d done=%0b exp st=3 done=1", status, done); end
    tests_run++; if (cycle_count !== 32'd8) begin tests_failed++; $display("FAIL timeout.cycles got %0d exp 8", cycle_count); end
    step();
    tests_run++; if (cycle_count !== 32'd8 || status !== 3'd3) begin tests_failed++; $display("FAIL timeout.sticky got st=%0d cyc=%0d exp st=3 cyc=8", status, cycle_count); end
  endtask

  task automatic test_halt_vs_timeout();
    do_reset();
    start_run();
    for (int i = 0; i < 7; i++) step();
    active = 1'b0; instr_address = '0; register_v0 = 32'h1234; step();
    tests_run++; if (status !== 3'd2) begin tests_failed++; $display("FAIL halt_wins.status got %0d exp 2", status); end
    tests_run++; if (result_v0 !== 32'h1234 || cycle_count !== 32'd8) begin tests_failed++; $display("FAIL halt_wins.data got res=%0h cyc=%0d exp res=1234 cyc=8", result_v0, cycle_count); end
  endtask

  task automatic test_active_drop();
    do_reset();
    start_run();
    step();
    active = 1'b0; instr_address = RV + 32'd8; register_v0 = 32'd77; step();
    tests_run++; if (status !== 3'd4 || err_code !== 2'd3) begin tests_failed++; $display("FAIL drop.err got st=%0d err=%0d exp st=4 err=3", status, err_code); end
    tests_run++; if (result_v0 !== 32'd0) begin tests_failed++; $display("FAIL drop.result got %0h exp 0", result_v0); end
  endtask

  task automatic test_enable_and_reset();
    do_reset();
    start_run();
    data_read = 1'b1; step();
    instr_address = RV + 32'd4; step();
    clk_enable = 1'b0; active = 1'b0; instr_address = '0; register_v0 = 32'd9;
    for (int i = 0; i < 5; i++) step();
    tests_run++; if (status !== 3'd1 || cycle_count !== 32'd2 || rd_count !== 32'd2) begin tests_failed++; $display("FAIL freeze got st=%0d cyc=%0d rd=%0d exp st=1 cyc=2 rd=2", status, cycle_count, rd_count); end
    clk_enable = 1'b1; active = 1'b1; instr_address = RV + 32'd8; data_read = 1'b0; step();
    tests_run++; if (cycle_count !== 32'd3) begin tests_failed++; $display("FAIL resume.cycles got %0d exp 3", cycle_count); end
    #2 reset = 1'b0;
    #1;
    tests_run++; if (status !== 3'd0 || {cycle_count, rd_count, wr_count} !== 96'd0) begin tests_failed++; $display("FAIL async_reset got st=%0d cyc=%0d rd=%0d wr=%0d exp all 0", status, cycle_count, rd_count, wr_count); end
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_halt();
    test_bad_first_fetch();
    test_rd_wr();
    test_timeout();
    test_halt_vs_timeout();
    test_active_drop();
    test_enable_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mips_cpu_run_monitor.md
Name: mips_cpu_run_monitor

Overview:
Synthesizable run-supervision block sitting downstream of mips_cpu_harvard, consuming its active, instr_address, register_v0 and data-bus strobes. Detects a clean halt (active low with instr_address 0), captures register_v0 at halt, counts cycles and data accesses, and flags timeout or protocol errors. Replaces ad-hoc per-bench halt checks with one status block shared by all CPU benches and an FPGA wrapper.

Parameters:
RESET_VECTOR, 32'hBFC00000, required first fetch address after active rises
MAX_CYCLES, 1000, RUN cycles allowed before timeout (>=2)
CW, 32, width of cycle and access counters

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
clk_enable  input  1  1 = advance; 0 = freeze all state and counters
active  input  1  CPU active flag
instr_address  input  32  CPU fetch address
register_v0  input  32  CPU $v0 debug output
data_read  input  1  CPU data read strobe
data_write  input  1  CPU data write strobe
status  output  3  0 IDLE, 1 RUN, 2 HALTED, 3 TIMEOUT, 4 ERROR
done  output  1  1 in HALTED, TIMEOUT or ERROR
result_v0  output  32  register_v0 captured on halt edge
cycle_count  output  CW  RUN cycles elapsed
rd_count  output  CW  data_read cycles during RUN
wr_count  output  CW  data_write cycles during RUN
err_code  output  2  0 none, 1 bad first fetch, 2 rd+wr together, 3 active dropped at non-zero PC

Behaviour:
- Reset (reset=0, async): status=IDLE, done=0, result_v0=0, all counters 0, err_code=0, first-fetch flag=1. Release is synchronous to next clk edge.
- All updates on rising clk only when clk_enable=1; clk_enable=0 holds every register and output.
- Outputs are registered; values reflect decisions one edge after inputs sampled.
- IDLE: active=1 -> RUN. active=0 -> stay IDLE (no halt detection before start).
- RUN, evaluated per edge, priority high to low:
  1. first-fetch flag=1 and instr_address != RESET_VECTOR -> ERROR, err_code=1.
  2. data_read=1 and data_write=1 -> ERROR, err_code=2.
  3. active=0 and instr_address==0 -> HALTED, result_v0<=register_v0.
  4. active=0 and instr_address!=0 -> ERROR, err_code=3.
  5. cycle_count==MAX_CYCLES-1 -> TIMEOUT.
  6. else stay RUN.
- First-fetch flag clears on the first RUN edge (the IDLE->RUN edge does not check it; check applies on the first edge with status=RUN).
- cycle_count increments on every enabled edge where status==RUN, including the exiting edge; saturates at all-ones.
- rd_count/wr_count increment on enabled RUN edges with the respective strobe high (also counted on an err_code=2 edge); saturate.
- Halt and timeout on same edge: HALTED wins. Error conditions win over both.
- HALTED, TIMEOUT, ERROR are sticky until reset; counters and result_v0 frozen; done=1.
- Reset asserted mid-RUN: immediate return to reset values regardless of clk.

Decomposition:
- Package mips_cpu_monitor_pkg: status enum (IDLE..ERROR, 3 bits), err_code constants, default RESET_VECTOR.
- One sub-module natural: mips_cpu_sat_counter (CW-wide, enable, async active-low clear, saturating), instantiated three times.

Test Plan:
- Reset release, active=1, fetch 0xBFC00000, then active=0 with instr_address=0 and register_v0=1 on 3rd RUN edge -> status=2, done=1, result_v0=1, cycle_count=3.
- First RUN edge with instr_address=0xBFC00004 -> status=4, err_code=1, cycle_count=1.
- data_read=1 for 2 RUN cycles, data_write=1 for 1, then data_read=data_write=1 -> status=4, err_code=2, rd_count=3, wr_count=2.
- MAX_CYCLES=8, never halt -> status=3 after 8th RUN edge, cycle_count=8; same run with halt on 8th edge -> status=2.
- active=0 with instr_address=0xBFC00008 during RUN -> status=4, err_code=3; result_v0 stays 0.
- clk_enable=0 for 5 edges mid-RUN -> cycle_count unchanged; assert reset between edges -> status=0, all counters 0 immediately.
